// File: rtl/alu_sequencer.sv
// alu_sequencer: command/result sequencer for the 16-bit ALU datapath.
// It takes one command at a time, drives the operand buses and the big-mux
// select, then returns the captured mux output over a valid/ready result port.
// Opcodes with cmdOp[3:2] == 2'b11 are iterated. Each pass feeds the mux output
// back as operand A, and the pass count comes from cmdB[CNT_W-1:0].
// Optional feature macro: ALU_SEQ_FLAGS_EN. When it is defined, resFlags
// carries the registered {N, Z} of resData. When it is not defined, resFlags
// is tied to 2'b00.

module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [3:0]       cmdOp,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  output logic [3:0]       muxSel,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] muxOut,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] resData,
  output logic [1:0]       resFlags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       opCode_q, opCode_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] resData_q, resData_d;

  logic             accept;
  logic             cmdIsIter;
  logic [CNT_W-1:0] cmdCnt;
  logic             resLoad;
  logic [WIDTH-1:0] resNext;

  // Decode the incoming command: iterated ops live in the top opcode quarter.
  always_comb begin
    accept    = cmdValid && cmdReady;
    cmdIsIter = (cmdOp[3:2] == 2'b11);
    cmdCnt    = cmdB[CNT_W-1:0];
  end

  // State register. An asynchronous reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A count of zero skips the function units entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmdIsIter) begin
            state_d = (cmdCnt == '0) ? DONE : ITER;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = DONE;
      end
      ITER: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. Only IDLE accepts work, only DONE presents a result, and the mux
  // select is parked at input 0 whenever no unit pass is in progress.
  always_comb begin
    cmdReady = (state_q == IDLE) && !rst;
    resValid = (state_q == DONE);
    muxSel   = 4'd0;
    case (state_q)
      EXEC:    muxSel = opCode_q;
      ITER:    muxSel = {2'b10, opCode_q[1:0]};
      default: muxSel = 4'd0;
    endcase
  end

  // Datapath next values. Operands hold unless a command is taken or an
  // iteration pass writes back into operand A. The result is loaded once,
  // on the final pass or directly from cmdA when the pass count is zero.
  always_comb begin
    opCode_d = opCode_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    cnt_d    = cnt_q;
    resLoad  = 1'b0;
    resNext  = muxOut;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opCode_d = cmdOp;
          opA_d    = cmdA;
          opB_d    = cmdB;
          cnt_d    = cmdCnt;
          if (cmdIsIter && (cmdCnt == '0)) begin
            resLoad = 1'b1;
            resNext = cmdA;
          end
        end
      end
      EXEC: begin
        resLoad = 1'b1;
        resNext = muxOut;
      end
      ITER: begin
        opA_d = muxOut;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resLoad = 1'b1;
          resNext = muxOut;
        end
      end
      default: begin
        resLoad = 1'b0;
      end
    endcase
    resData_d = resLoad ? resNext : resData_q;
  end

  // Datapath registers. They are cleared on reset so an aborted op leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opCode_q  <= 4'd0;
      opA_q     <= '0;
      opB_q     <= '0;
      cnt_q     <= '0;
      resData_q <= '0;
    end else begin
      opCode_q  <= opCode_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      cnt_q     <= cnt_d;
      resData_q <= resData_d;
    end
  end

  assign opA     = opA_q;
  assign opB     = opB_q;
  assign resData = resData_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  // Flags are computed from the value being loaded into resData, so they
  // always update in the same cycle as the result.
  always_comb begin
    flags_d = flags_q;
    if (resLoad) begin
      flags_d = {resNext[WIDTH-1], (resNext == '0)};
    end
  end

  // Flag register. It holds alongside resData while DONE waits for resReady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign resFlags = flags_q;
`else
  assign resFlags = 2'b00;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: a scoreboard bench for alu_sequencer.
// It provides a stand-in ALU that drives muxOut. Every accepted command
// pushes its expected result, flags and result cycle into a queue. A monitor
// pops and compares an entry whenever the sequencer hands over a result.

module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [3:0]  cmdOp;
  logic [15:0] cmdA;
  logic [15:0] cmdB;
  logic [3:0]  muxSel;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [15:0] muxOut;
  logic        resValid;
  logic        resReady;
  logic [15:0] resData;
  logic [1:0]  resFlags;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  flags;
    int          validCycle;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   readyMode = 1;
  bit   sawValid = 0;

  alu_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
    .muxSel(muxSel), .opA(opA), .opB(opB), .muxOut(muxOut),
    .resValid(resValid), .resReady(resReady),
    .resData(resData), .resFlags(resFlags)
  );

  // Stand-in function units. Inputs 12..15 are unconnected and read as zero.
  function automatic logic [15:0] aluUnit(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a << 1;
      4'd6:    return a >> 1;
      4'd7:    return b;
      4'd8:    return ~a;
      4'd9:    return a + 16'd1;
      4'd10:   return a - 16'd1;
      4'd11:   return {a[14:0], a[15]};
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural result: one unit evaluation, or n repeated evaluations that feed back into A.
  function automatic logic [15:0] refResult(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] acc;
    int n;
    if (op[3:2] != 2'b11) return aluUnit(op, a, b);
    acc = a;
    n = b[3:0];
    for (int i = 0; i < n; i++) acc = aluUnit(op - 4'd4, acc, b);
    return acc;
  endfunction

  function automatic logic [1:0] refFlags(input logic [15:0] d);
`ifdef ALU_SEQ_FLAGS_EN
    return {d[15], d == 16'h0000};
`else
    return 2'b00 & {d[15], 1'b0};
`endif
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [15:0] b);
    if (op[3:2] != 2'b11) return 2;
    return int'(b[3:0]) + 1;
  endfunction

  always_comb muxOut = aluUnit(muxSel, opA, opB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // The consumer changes resReady just after the rising edge, so the negedge monitor sees a stable value.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: resReady = ($urandom_range(0, 3) != 0);
      1: resReady = 1'b1;
      default: resReady = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Monitor: compares each presented result against the head of the queue.
  always @(negedge clk) begin
    if (!rst && resValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 32'(resValid), 32'd0);
      end else begin
        if (!sawValid) begin
          checkOutput("resultLatency", 32'(cycle), 32'(expQ[0].validCycle));
          sawValid = 1'b1;
        end
        checkOutput("resData", 32'(resData), 32'(expQ[0].data));
        checkOutput("resFlags", 32'(resFlags), 32'(expQ[0].flags));
        checkOutput("cmdReadyInDone", 32'(cmdReady), 32'd0);
        if (resReady) begin
          void'(expQ.pop_front());
          sawValid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int waited);
    exp_t e;
    @(negedge clk);
    cmdValid = 1'b1;
    cmdOp = op;
    cmdA = a;
    cmdB = b;
    waited = 0;
    while (!cmdReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmdReady) begin
      checkOutput("acceptTimeout", 32'(cmdReady), 32'd1);
      cmdValid = 1'b0;
    end else begin
      e.data = refResult(op, a, b);
      e.flags = refFlags(e.data);
      e.validCycle = cycle + refLatency(op, b);
      expQ.push_back(e);
      @(posedge clk);
      #1 cmdValid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmdReady"}, 32'(cmdReady), 32'd0);
    checkOutput({tag, "_muxSel"}, 32'(muxSel), 32'd0);
    checkOutput({tag, "_opA"}, 32'(opA), 32'd0);
    checkOutput({tag, "_opB"}, 32'(opB), 32'd0);
    checkOutput({tag, "_resValid"}, 32'(resValid), 32'd0);
    checkOutput({tag, "_resData"}, 32'(resData), 32'd0);
    checkOutput({tag, "_resFlags"}, 32'(resFlags), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1;
    cmdValid = 1'b0;
    cmdOp = 4'd0;
    cmdA = 16'h0;
    cmdB = 16'h0;
    resReady = 1'b0;

    // Reset, then idle
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleCmdReady", 32'(cmdReady), 32'd1);
    checkOutput("idleResValid", 32'(resValid), 32'd0);

    // Single-pass NOT
    readyMode = 1;
    applyStimulus(4'd8, 16'h00FF, 16'h5555, w);
    @(negedge clk);
    checkOutput("notMuxSel", 32'(muxSel), 32'd8);
    waitDrain();

    // Iterated NOT, three passes, then zero passes
    applyStimulus(4'd12, 16'h1234, 16'h0003, w);
    @(negedge clk);
    checkOutput("iterMuxSel", 32'(muxSel), 32'd8);
    checkOutput("iterOpB", 32'(opB), 32'h0003);
    waitDrain();
    applyStimulus(4'd12, 16'h1234, 16'h0000, w);
    waitDrain();

    // Zero flag from a single-pass AND
    applyStimulus(4'd0, 16'h00F0, 16'h0F00, w);
    waitDrain();

    // Backpressure: hold the result and offer a second command meanwhile
    readyMode = 2;
    applyStimulus(4'd1, 16'h8001, 16'h0F00, w);
    w = 0;
    while (!resValid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bpReachedDone", 32'(resValid), 32'd1);
    cmdValid = 1'b1;
    cmdOp = 4'd9;
    cmdA = 16'h7FFF;
    cmdB = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpCmdReady", 32'(cmdReady), 32'd0);
      checkOutput("bpResValid", 32'(resValid), 32'd1);
    end
    cmdValid = 1'b0;
    readyMode = 1;
    applyStimulus(4'd9, 16'h7FFF, 16'h0000, w);
    checkOutput("bpAcceptWait", 32'(w), 32'd1);
    waitDrain();

    // Reset in the middle of an iterated op
    applyStimulus(4'd12, 16'hA5A5, 16'h000A, w);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    expQ.delete();
    sawValid = 1'b0;
    @(negedge clk);
    checkResetOutputs("midReset");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("postAbortValid", 32'(resValid), 32'd0);
    applyStimulus(4'd13, 16'hFFFE, 16'h0002, w);
    waitDrain();

    // Randomized commands with random consumer backpressure
    readyMode = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), w);
    end
    waitDrain();
    readyMode = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
